// File: rtl/led_shift_pkg.sv
// Shared constants and FSM state type for the LED driver serializer.
package led_shift_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 16;
  localparam int unsigned DEFAULT_CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_LATCH
  } state_e;

endpackage

// File: rtl/led_shift_tick.sv
// Phase counter: strobes phase_end on the CLK_DIV-th cycle after the last clear.
module led_shift_tick
  import led_shift_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic phase_end
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || phase_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_shift_driver.sv
// Serializes a parallel LED word onto a divided serial clock, then latches it
// into the daisy-chained drivers; one pending word may queue during a shift.
module led_shift_driver
  import led_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             sdata,
  output logic             sclk,
  output logic             latch
);

  localparam int unsigned   BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [WIDTH-1:0] pend_q, pend_d, start_word;
  logic             pend_vld_q, pend_vld_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sdata_q, sdata_d, sclk_q, sclk_d, latch_q, latch_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             start, phase_end, tick_clear;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  led_shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (tick_clear),
    .phase_end (phase_end)
  );

  assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bit_cnt_d  = bit_cnt_q;
    sdata_d    = sdata_q;
    sclk_d     = sclk_q;
    latch_d    = latch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    start      = 1'b0;
    start_word = data_in;

    if (load && state_q != ST_IDLE) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (load) start = 1'b1;
      ST_LOW: if (phase_end) begin
        state_d = ST_HIGH;
        sclk_d  = 1'b1;
      end
      ST_HIGH: if (phase_end) begin
        sclk_d = 1'b0;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_LATCH;
          latch_d = 1'b1;
        end else begin
          state_d   = ST_LOW;
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = shifted;
          sdata_d   = first_bit(shifted);
        end
      end
      ST_LATCH: if (phase_end) begin
        latch_d = 1'b0;
        done_d  = 1'b1;
        // A load on this very edge is the newest word and supersedes the buffer.
        if (load) begin
          start      = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          start      = 1'b1;
          start_word = pend_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          sdata_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d   = ST_LOW;
      shreg_d   = start_word;
      bit_cnt_d = '0;
      sdata_d   = first_bit(start_word);
      sclk_d    = 1'b0;
      busy_d    = 1'b1;
    end

    tick_clear = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      sdata_q    <= 1'b0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      sdata_q    <= sdata_d;
      sclk_q     <= sclk_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sdata = sdata_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;

endmodule
